// File: rtl/hls_slave_harness_ctrl_if.sv
// Bundle between the harness sequencer, its vector source/sink and the HLS slave port.
// The master side is the harness; the slave side is the environment around it.
interface hls_slave_harness_ctrl_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned CNT_W  = 32
);
    logic                cmd_go;
    logic [ADDR_W-1:0]   cfg_load_base;
    logic [LEN_W-1:0]    cfg_load_len;
    logic [ADDR_W-1:0]   cfg_dump_base;
    logic [LEN_W-1:0]    cfg_dump_len;
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          S_oe_ram;
    logic [1:0]          S_we_ram;
    logic [2*ADDR_W-1:0] S_addr_ram;
    logic [15:0]         S_Wdata_ram;
    logic [7:0]          S_data_ram_size;
    logic [15:0]         Sout_Rdata_ram;
    logic [1:0]          Sout_DataRdy;
    logic                start_port;
    logic                done_port;
    logic                busy;
    logic                finished;
    logic                timeout;
    logic [CNT_W-1:0]    cycles;

    modport master (
        input  cmd_go, cfg_load_base, cfg_load_len, cfg_dump_base, cfg_dump_len,
        input  in_data, in_valid, out_ready, Sout_Rdata_ram, Sout_DataRdy, done_port,
        output in_ready, out_data, out_valid, S_oe_ram, S_we_ram, S_addr_ram,
        output S_Wdata_ram, S_data_ram_size, start_port, busy, finished, timeout, cycles
    );

    modport slave (
        output cmd_go, cfg_load_base, cfg_load_len, cfg_dump_base, cfg_dump_len,
        output in_data, in_valid, out_ready, Sout_Rdata_ram, Sout_DataRdy, done_port,
        input  in_ready, out_data, out_valid, S_oe_ram, S_we_ram, S_addr_ram,
        input  S_Wdata_ram, S_data_ram_size, start_port, busy, finished, timeout, cycles
    );
endinterface

// File: rtl/hls_slave_harness_ctrl.sv
// Sequencer for an HLS top's slave memory port: load a byte vector, pulse start,
// time the run until done, then read a result window back out as a byte stream.
module hls_slave_harness_ctrl #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 200000000
) (
    input  logic                          clock,
    input  logic                          reset,
    hls_slave_harness_ctrl_if.master      bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP_REQ, S_DUMP_WAIT, S_DUMP_OUT, S_FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  load_base_q, load_base_d;
    logic [LEN_W-1:0]   load_len_q, load_len_d;
    logic [ADDR_W-1:0]  dump_base_q, dump_base_d;
    logic [LEN_W-1:0]   dump_len_q, dump_len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         out_data_q, out_data_d;

    logic [LEN_W-1:0]   idx_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               we0, oe0, start, in_rdy;
    logic [ADDR_W-1:0]  addr0;
    logic [7:0]         wdata0;
    logic               unused_ok;

    assign idx_inc = idx_q + LEN_W'(1);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            load_base_q <= '0;
            load_len_q  <= '0;
            dump_base_q <= '0;
            dump_len_q  <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            cycles_q    <= '0;
            timeout_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            load_base_q <= load_base_d;
            load_len_q  <= load_len_d;
            dump_base_q <= dump_base_d;
            dump_len_q  <= dump_len_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cycles_q    <= cycles_d;
            timeout_q   <= timeout_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_base_d = load_base_q;
        load_len_d  = load_len_q;
        dump_base_d = dump_base_q;
        dump_len_d  = dump_len_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cycles_d    = cycles_q;
        timeout_d   = timeout_q;
        out_data_d  = out_data_q;
        in_rdy      = 1'b0;
        we0         = 1'b0;
        oe0         = 1'b0;
        start       = 1'b0;
        addr0       = '0;
        wdata0      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_go) begin
                    load_base_d = bus.cfg_load_base;
                    load_len_d  = bus.cfg_load_len;
                    dump_base_d = bus.cfg_dump_base;
                    dump_len_d  = bus.cfg_dump_len;
                    timeout_d   = 1'b0;
                    idx_d       = '0;
                    state_d     = (bus.cfg_load_len != '0) ? S_LOAD : S_START;
                end
            end
            S_LOAD: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    we0    = 1'b1;
                    addr0  = load_base_q + ADDR_W'(idx_q);
                    wdata0 = bus.in_data;
                    idx_d  = idx_inc;
                    // idx is reused for the dump window, so rewind it on exit
                    if (idx_inc == load_len_q) begin
                        idx_d   = '0;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                start   = 1'b1;
                cnt_d   = CNT_W'(1);
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (bus.done_port) begin
                    cycles_d = cnt_inc;
                    state_d  = (dump_len_q != '0) ? S_DUMP_REQ : S_FINISH;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    cycles_d  = CNT_W'(TIMEOUT);
                    state_d   = S_FINISH;
                end
            end
            S_DUMP_REQ: begin
                oe0     = 1'b1;
                addr0   = dump_base_q + ADDR_W'(idx_q);
                state_d = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (bus.Sout_DataRdy[0]) begin
                    out_data_d = bus.Sout_Rdata_ram[7:0];
                    state_d    = S_DUMP_OUT;
                end
            end
            S_DUMP_OUT: begin
                if (bus.out_ready) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == dump_len_q) ? S_FINISH : S_DUMP_REQ;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready        = in_rdy;
    assign bus.out_data        = out_data_q;
    assign bus.out_valid       = (state_q == S_DUMP_OUT);
    assign bus.S_we_ram        = {1'b0, we0};
    assign bus.S_oe_ram        = {1'b0, oe0};
    assign bus.S_addr_ram      = {{ADDR_W{1'b0}}, addr0};
    assign bus.S_Wdata_ram     = {8'h00, wdata0};
    assign bus.S_data_ram_size = {4'h0, ((we0 || oe0) ? 4'd8 : 4'd0)};
    assign bus.start_port      = start;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.finished        = (state_q == S_FINISH);
    assign bus.timeout         = timeout_q;
    assign bus.cycles          = cycles_q;

    assign unused_ok = ^{bus.Sout_Rdata_ram[15:8], bus.Sout_DataRdy[1]};
endmodule

// File: tb/tb_hls_slave_harness_ctrl.sv
// Directed bench: behavioural slave memory, sorting accelerator stub and a stalling sink
// around the harness, with hand-computed expectations checked by immediate assertions.
module tb_hls_slave_harness_ctrl;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned TMO    = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hls_slave_harness_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    hls_slave_harness_ctrl #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .TIMEOUT(TMO)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [128];
    int wr_addr [$];
    int wr_data [$];
    int wr_cyc  [$];
    int wr_cnt = 0, oe_cnt = 0, start_cnt = 0, overlap = 0, ch1_bad = 0, size_bad = 0;
    int cyc = 0, rd_wait = 0, rd_lat = 2, rd_addr = 0, dn_wait = 0, done_dly = 0;

    logic [7:0] vec [4];
    logic [7:0] got [8];
    int nbytes = 0, stalls = 0, stab_bad = 0, fin_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // accelerator stub: ascending sort of the 4-byte window at 0x10 when it reports done
    task automatic sort4();
        logic [7:0] t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (mem[16+j] > mem[17+j]) begin
                    t = mem[16+j]; mem[16+j] = mem[17+j]; mem[17+j] = t;
                end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        bus.Sout_DataRdy   = '0;
        bus.Sout_Rdata_ram = '0;
        bus.done_port      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.Sout_DataRdy = '0;
            bus.done_port    = 1'b0;
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin
                    bus.Sout_DataRdy   = 2'b01;
                    bus.Sout_Rdata_ram = {8'h00, mem[rd_addr]};
                end
            end
            if (dn_wait > 0) begin
                dn_wait--;
                if (dn_wait == 0) begin
                    bus.done_port = 1'b1;
                    sort4();
                end
            end
            @(negedge clk);
            if (bus.S_we_ram[0] && bus.S_oe_ram[0]) overlap++;
            if (bus.S_we_ram[1] || bus.S_oe_ram[1] || bus.S_addr_ram[2*ADDR_W-1:ADDR_W] != '0 ||
                bus.S_Wdata_ram[15:8] != 8'h00 || bus.S_data_ram_size[7:4] != 4'h0) ch1_bad++;
            if ((bus.S_we_ram[0] || bus.S_oe_ram[0]) ? (bus.S_data_ram_size[3:0] != 4'd8)
                                                      : (bus.S_data_ram_size[3:0] != 4'd0)) size_bad++;
            if (bus.S_we_ram[0]) begin
                mem[bus.S_addr_ram[ADDR_W-1:0]] = bus.S_Wdata_ram[7:0];
                wr_addr.push_back(int'(bus.S_addr_ram[ADDR_W-1:0]));
                wr_data.push_back(int'(bus.S_Wdata_ram[7:0]));
                wr_cyc.push_back(cyc);
                wr_cnt++;
            end
            if (bus.S_oe_ram[0]) begin
                oe_cnt++;
                rd_addr = int'(bus.S_addr_ram[ADDR_W-1:0]);
                rd_wait = rd_lat;
            end
            if (bus.start_port) begin
                start_cnt++;
                dn_wait = done_dly;
            end
        end
    end

    // pulse cmd_go, then scramble cfg so that only latched values can be used
    task automatic go(input logic [6:0] lb, input logic [7:0] ll, input logic [6:0] db, input logic [7:0] dl);
        bus.cfg_load_base = lb;
        bus.cfg_load_len  = ll;
        bus.cfg_dump_base = db;
        bus.cfg_dump_len  = dl;
        bus.cmd_go        = 1'b1;
        tick();
        bus.cmd_go        = 1'b0;
        bus.cfg_load_base = 7'h55;
        bus.cfg_load_len  = 8'hFF;
        bus.cfg_dump_base = 7'h2A;
        bus.cfg_dump_len  = 8'hFF;
    endtask

    task automatic load4(input bit toggle);
        int k = 0;
        int c = 0;
        while (k < 4 && c < 40) begin
            bus.in_valid = toggle ? ((c % 2) == 0) : 1'b1;
            bus.in_data  = vec[k];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            tick();
            c++;
        end
        bus.in_valid = 1'b0;
        chk("load_handshakes", k, 4);
    endtask

    task automatic run_finish(input int stall_byte, input int stall_n);
        int nb = 0, st = 0, fin = 0, post = 0, c = 0;
        logic [7:0] held = 8'h00;
        while (c < 300 && !(fin > 0 && post >= 3)) begin
            bus.out_ready = bus.out_valid && !(nb == stall_byte && st < stall_n);
            @(negedge clk);
            if (fin > 0) post++;
            if (bus.finished) fin++;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (nb == stall_byte && st > 0 && bus.out_data !== held) stab_bad++;
                    if (nb < 8) got[nb] = bus.out_data;
                    nb++;
                end else begin
                    if (st == 0) held = bus.out_data;
                    else if (bus.out_data !== held) stab_bad++;
                    st++;
                end
            end
            tick();
            c++;
        end
        bus.out_ready = 1'b0;
        nbytes     = nb;
        stalls     = st;
        fin_pulses = fin;
        chk("finish_seen", (fin > 0), 1);
    endtask

    initial begin
        int wb, ob, sb, found;
        logic [7:0] exp_s [4];
        exp_s = '{8'h01, 8'h07, 8'h20, 8'h33};
        bus.cmd_go = 1'b0;
        bus.cfg_load_base = '0; bus.cfg_load_len = '0;
        bus.cfg_dump_base = '0; bus.cfg_dump_len = '0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ctrl", {bus.in_ready, bus.out_valid, bus.start_port, bus.finished, bus.timeout}, 0);
        chk("rst_mem_port", {bus.S_we_ram, bus.S_oe_ram, bus.S_addr_ram, bus.S_Wdata_ram[7:0]}, 0);
        chk("rst_size", bus.S_data_ram_size, 0);
        chk("rst_cycles", bus.cycles, 0);
        chk("rst_out_data", bus.out_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // run 1: continuous load at 0x10, done 9 cycles after start, stalled dump
        vec = '{8'h33, 8'h01, 8'h20, 8'h07};
        done_dly = 9; rd_lat = 2;
        wb = wr_cnt; ob = oe_cnt; sb = start_cnt;
        go(7'h10, 8'd4, 7'h10, 8'd4);
        chk("busy_after_go", bus.busy, 1);
        load4(1'b0);
        @(negedge clk);
        chk("start_after_load", bus.start_port, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("r1_wr_addr", wr_addr[wb+i], 32'h10 + i);
            chk("r1_wr_data", wr_data[wb+i], vec[i]);
        end
        chk("r1_wr_contig_cycles", wr_cyc[wb+3] - wr_cyc[wb], 3);
        run_finish(2, 3);
        chk("r1_wr_count", wr_cnt - wb, 4);
        chk("r1_start_count", start_cnt - sb, 1);
        chk("r1_cycles", bus.cycles, 10);
        chk("r1_fin_pulses", fin_pulses, 1);
        chk("r1_busy_low", bus.busy, 0);
        chk("r1_timeout", bus.timeout, 0);
        chk("r1_oe_count", oe_cnt - ob, 4);
        chk("r1_nbytes", nbytes, 4);
        for (int i = 0; i < 4; i++) chk("r1_out_byte", got[i], exp_s[i]);
        chk("r1_stall_cycles", stalls, 3);
        chk("r1_stall_stable", stab_bad, 0);

        // run 2: toggled in_valid, base wraps past the top of the address space
        vec = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        done_dly = 3;
        wb = wr_cnt; ob = oe_cnt;
        go(7'h7E, 8'd4, 7'h00, 8'd0);
        load4(1'b1);
        run_finish(-1, 0);
        chk("r2_wr_count", wr_cnt - wb, 4);
        for (int i = 0; i < 4; i++) begin
            chk("r2_wr_addr", wr_addr[wb+i], (32'h7E + i) & 32'h7F);
            chk("r2_wr_data", wr_data[wb+i], vec[i]);
        end
        for (int i = 1; i < 4; i++) chk("r2_wr_spacing", wr_cyc[wb+i] - wr_cyc[wb+i-1], 2);
        chk("r2_oe_count", oe_cnt - ob, 0);
        chk("r2_cycles", bus.cycles, 4);

        // run 3: zero lengths, done in the cycle after start
        done_dly = 1;
        wb = wr_cnt; ob = oe_cnt; sb = start_cnt;
        go(7'h10, 8'd0, 7'h10, 8'd0);
        @(negedge clk);
        chk("r3_start_direct", bus.start_port, 1);
        tick();
        run_finish(-1, 0);
        chk("r3_no_writes", wr_cnt - wb, 0);
        chk("r3_no_reads", oe_cnt - ob, 0);
        chk("r3_start_count", start_cnt - sb, 1);
        chk("r3_cycles", bus.cycles, 2);
        chk("r3_fin_pulses", fin_pulses, 1);

        // run 4: done never arrives, then the next go clears the sticky flag
        done_dly = 0;
        go(7'h00, 8'd0, 7'h00, 8'd4);
        run_finish(-1, 0);
        chk("r4_timeout", bus.timeout, 1);
        chk("r4_cycles", bus.cycles, TMO);
        chk("r4_no_dump", nbytes, 0);
        done_dly = 1;
        go(7'h00, 8'd0, 7'h00, 8'd0);
        @(negedge clk);
        chk("r4_timeout_cleared", bus.timeout, 0);
        tick();
        run_finish(-1, 0);
        chk("r4_rerun_cycles", bus.cycles, 2);

        // run 5: reset while a slow read is outstanding
        done_dly = 1; rd_lat = 5;
        ob = oe_cnt;
        go(7'h00, 8'd0, 7'h10, 8'd2);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (bus.S_oe_ram[0]) found = 1;
            tick();
        end
        chk("r5_read_issued", found, 1);
        rst = 1'b1;
        #1;
        chk("r5_rst_busy", bus.busy, 0);
        chk("r5_rst_ports", {bus.S_we_ram, bus.S_oe_ram, bus.start_port, bus.out_valid}, 0);
        chk("r5_rst_cycles", bus.cycles, 0);
        repeat (6) tick();
        rst = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("r5_idle_busy", bus.busy, 0);
        chk("r5_idle_out_valid", bus.out_valid, 0);
        chk("r5_idle_out_data", bus.out_data, 0);
        chk("r5_one_read", oe_cnt - ob, 1);

        chk("we_oe_overlap", overlap, 0);
        chk("ch1_tied_zero", ch1_bad, 0);
        chk("size_field", size_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hls_slave_harness_ctrl.md
Name: hls_slave_harness_ctrl

Overview:
- Synthesizable sequencer that drives one HLS-generated top (mergesort `main` class) through its slave memory port.
- Streams an input byte vector into accelerator memory, pulses `start_port`, and counts cycles until `done_port`.
- Reads a result window back and emits it as a byte stream.
- Sits between the vector source (host/FIFO) and the accelerator. It replaces the file-driven stimulus and result logging on hardware/emulation runs.

Parameters:
- ADDR_W, 7, per-channel slave address width; port carries 2 channels.
- LEN_W, 8, width of load/dump length registers (max 255 bytes).
- CNT_W, 32, cycle counter width.
- TIMEOUT, 200000000, cycle limit before abort.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_go  in  1  one-cycle pulse; starts a run when idle (ignored while busy).
- cfg_load_base  in  ADDR_W  first write address.
- cfg_load_len  in  LEN_W  bytes to load.
- cfg_dump_base  in  ADDR_W  first readback address.
- cfg_dump_len  in  LEN_W  bytes to read back.
- in_data  in  8  input byte.
- in_valid  in  1  input byte valid.
- in_ready  out  1  high only in LOAD.
- out_data  out  8  readback byte.
- out_valid  out  1  readback byte valid.
- out_ready  in  1  consumer accepts.
- S_oe_ram  out  2  read enable per channel (only bit 0 used).
- S_we_ram  out  2  write enable per channel (only bit 0 used).
- S_addr_ram  out  2*ADDR_W  address; channel 0 in [ADDR_W-1:0].
- S_Wdata_ram  out  16  write data; channel 0 in [7:0].
- S_data_ram_size  out  8  access size in bits; channel 0 in [3:0].
- Sout_Rdata_ram  in  16  read data; channel 0 in [7:0].
- Sout_DataRdy  in  2  read data valid; bit 0 used.
- start_port  out  1  accelerator start.
- done_port  in  1  accelerator done.
- busy  out  1  high from accepted cmd_go to FINISH.
- finished  out  1  one-cycle pulse in FINISH.
- timeout  out  1  sticky; set on abort, cleared by next cmd_go.
- cycles  out  CNT_W  last measured cycle count.

Behaviour:
- Reset values:
  - All outputs 0, state IDLE, cycles 0.
  - Channel-1 slices of S_* outputs are tied 0 at all times.
  - S_data_ram_size[3:0]=8 during S_we/S_oe assertion, 0 otherwise.
- Reset asserted mid-run: immediate return to IDLE; start_port/S_we/S_oe drop asynchronously. An in-flight read response is ignored.
- States:
  - IDLE: on cmd_go, latch all cfg_* and clear timeout and idx. Go to LOAD if cfg_load_len!=0, else START.
  - LOAD:
    - in_ready=1. On in_valid&in_ready: S_we_ram[0]=1 that cycle (combinational from handshake), addr=load_base+idx (mod 2^ADDR_W wrap), Wdata[7:0]=in_data, idx++.
    - After byte load_len-1 is accepted, go to START. Exactly one byte per cycle max.
  - START: start_port=1 for exactly one cycle; counter := 1; go to RUN.
  - RUN:
    - Counter increments each cycle.
    - If done_port=1: cycles := counter (count includes the start cycle; done in the cycle after start gives 2). Go to DUMP_REQ if dump_len!=0, else FINISH.
    - If counter reaches TIMEOUT with done_port low: timeout:=1, cycles:=TIMEOUT, go to FINISH.
    - done_port high during START is not sampled.
  - DUMP_REQ: S_oe_ram[0]=1 for one cycle, addr=dump_base+idx; go to DUMP_WAIT.
  - DUMP_WAIT:
    - Wait for Sout_DataRdy[0]; capture Rdata[7:0] into out_data, go to DUMP_OUT. Latency is arbitrary (≥1).
    - Sout_DataRdy in any other state is ignored.
  - DUMP_OUT: out_valid=1 and held stable until out_ready. On handshake idx++; go to DUMP_REQ if more bytes remain, else FINISH.
  - FINISH: finished=1, busy=0 next cycle; go to IDLE.
- Never more than one outstanding read; S_we and S_oe are never high together.

Test Plan:
- Load 4 bytes {0x33,0x01,0x20,0x07} at base 0x10, in_valid continuous: exactly 4 write cycles at addresses 0x10..0x13, then one start_port pulse.
- Load with in_valid toggled 1/0: 4 writes occur only on handshake cycles, and addresses stay contiguous.
- done_port model asserts 9 cycles after start_port: cycles=10, finished pulses once, busy falls.
- Dump 4 bytes at 0x10 with 2-cycle read latency and out_ready low for 3 cycles on byte 2: out stream is 0x01,0x07,0x20,0x33 (sorted), with out_data stable while stalled.
- cfg_load_len=0 and cfg_dump_len=0: no S_we or S_oe activity; IDLE→START→RUN→FINISH.
- TIMEOUT=50 with done_port stuck low: timeout=1, cycles=50. A following cmd_go clears timeout. Reset asserted during DUMP_WAIT returns to IDLE, all outputs 0.
